// File: rtl/counter_xn.sv
// ---------------------------------------------------------------------------
// counter_xn
// N_CH independent timer/counter channels on the MIO counter window. Each
// channel has a prescaler and one of four modes: one-shot, auto-reload, PWM
// and free-run up.
//
// Ports
//   clk          rising-edge system clock
//   RSTN         asynchronous active-low reset
//   counter_we   register write strobe
//   counter_ch   channel targeted by the write (ignored for STATUS)
//   counter_reg  0=LOAD 1=CTRL 2=CMP 3=STATUS(W1C)
//   counter_val  write data
//   rd_ch        channel whose count drives counter_out
//   counter_out  current count of rd_ch, 0 when rd_ch >= N_CH
//   counter_OUT  per-channel output (pulse or level, depending on mode)
//   irq_pend     sticky per-channel pending flags
//   irq          OR over (irq_pend & irq_en)
//
// CTRL layout: [0] en, [2:1] mode, [3] irq_en, [4 +: PRESC_W] presc_div
// ---------------------------------------------------------------------------
module counter_xn #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               RSTN,
    input  logic               counter_we,
    input  logic [CH_W-1:0]    counter_ch,
    input  logic [1:0]         counter_reg,
    input  logic [CNT_W-1:0]   counter_val,
    input  logic [CH_W-1:0]    rd_ch,
    output logic [CNT_W-1:0]   counter_out,
    output logic [N_CH-1:0]    counter_OUT,
    output logic [N_CH-1:0]    irq_pend,
    output logic               irq
);

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_PWM     = 2'b10;
    localparam logic [1:0] MODE_FREERUN = 2'b11;

    logic [CNT_W-1:0] w_cnt [N_CH];
    logic [N_CH-1:0]  w_irq_en;
    logic [N_CH-1:0]  w_clr;

    // STATUS clears act on every channel at once; the channel field is ignored.
    assign w_clr = (counter_we && (counter_reg == REG_STATUS)) ?
                   counter_val[N_CH-1:0] : {N_CH{1'b0}};

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0]   r_load;
        logic [CNT_W-1:0]   r_cmp;
        logic [CNT_W-1:0]   r_cnt;
        logic [PRESC_W-1:0] r_div;
        logic [PRESC_W-1:0] r_presc;
        logic [1:0]         r_mode;
        logic               r_en;
        logic               r_irq_en;
        logic               r_out;
        logic               r_pend;

        logic               w_hit;
        logic               w_ld;
        logic               w_ctl;
        logic               w_cmpw;
        logic               w_tick;
        logic               w_adv;
        logic               w_set;
        logic               w_out_nxt;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [PRESC_W-1:0] w_presc_nxt;

        assign w_hit  = counter_we && (counter_ch == CH_W'(gi));
        assign w_ld   = w_hit && (counter_reg == REG_LOAD);
        assign w_ctl  = w_hit && (counter_reg == REG_CTRL);
        assign w_cmpw = w_hit && (counter_reg == REG_CMP);
        assign w_tick = r_en && (r_presc == r_div);
        // A LOAD or CTRL write on this channel swallows the tick of that cycle.
        assign w_adv  = w_tick && !w_ld && !w_ctl;

        // Prescaler next value: restart on an en 0->1 write, run only while enabled.
        always_comb begin
            w_presc_nxt = r_presc;
            if (w_ctl && counter_val[0] && !r_en) begin
                w_presc_nxt = {PRESC_W{1'b0}};
            end else if (r_en) begin
                w_presc_nxt = w_tick ? {PRESC_W{1'b0}} : (r_presc + PRESC_W'(1));
            end else begin
                w_presc_nxt = r_presc;
            end
        end

        // Count / output / interrupt-set next state per mode, writes override.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_out_nxt = r_out;
            w_set     = 1'b0;
            case (r_mode)
                MODE_ONESHOT: begin
                    // Output is a sticky "done" level in this mode.
                    if (w_adv && (r_cnt > CNT_W'(1))) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (w_adv && (r_cnt == CNT_W'(1))) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        w_out_nxt = 1'b1;
                        w_set     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                MODE_RELOAD: begin
                    w_out_nxt = 1'b0;
                    if (w_adv && (r_cnt == {CNT_W{1'b0}})) begin
                        w_cnt_nxt = r_load;
                        w_out_nxt = 1'b1;
                        w_set     = 1'b1;
                    end else if (w_adv) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                MODE_PWM: begin
                    // Output follows the current count every cycle, one clock late.
                    w_out_nxt = (r_cnt < r_cmp);
                    if (w_adv && (r_cnt == {CNT_W{1'b0}})) begin
                        w_cnt_nxt = r_load;
                    end else if (w_adv) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                MODE_FREERUN: begin
                    w_out_nxt = 1'b0;
                    if (w_adv) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == {CNT_W{1'b1}}) begin
                            w_out_nxt = 1'b1;
                            w_set     = 1'b1;
                        end else begin
                            w_set     = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                default: begin
                    w_cnt_nxt = r_cnt;
                    w_out_nxt = r_out;
                    w_set     = 1'b0;
                end
            endcase

            if (w_ld) begin
                w_cnt_nxt = counter_val;
                // LOAD re-arms a one-shot, so its done level drops.
                if (r_mode == MODE_ONESHOT) begin
                    w_out_nxt = 1'b0;
                end else begin
                    w_out_nxt = w_out_nxt;
                end
            end else begin
                w_cnt_nxt = w_cnt_nxt;
            end

            // Any CTRL write drops a one-shot done level; a mode change drops any output.
            if (w_ctl && ((counter_val[2:1] != r_mode) || (r_mode == MODE_ONESHOT))) begin
                w_out_nxt = 1'b0;
            end else begin
                w_out_nxt = w_out_nxt;
            end
        end

        // Channel register file and counter state.
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                r_load   <= {CNT_W{1'b0}};
                r_cmp    <= {CNT_W{1'b0}};
                r_cnt    <= {CNT_W{1'b0}};
                r_div    <= {PRESC_W{1'b0}};
                r_presc  <= {PRESC_W{1'b0}};
                r_mode   <= 2'b00;
                r_en     <= 1'b0;
                r_irq_en <= 1'b0;
                r_out    <= 1'b0;
                r_pend   <= 1'b0;
            end else begin
                if (w_ld) begin
                    r_load <= counter_val;
                end
                if (w_cmpw) begin
                    r_cmp <= counter_val;
                end
                if (w_ctl) begin
                    r_en     <= counter_val[0];
                    r_mode   <= counter_val[2:1];
                    r_irq_en <= counter_val[3];
                    r_div    <= counter_val[4 +: PRESC_W];
                end
                r_cnt   <= w_cnt_nxt;
                r_presc <= w_presc_nxt;
                r_out   <= w_out_nxt;
                // A set event beats a same-cycle W1C.
                r_pend  <= w_set | (r_pend & ~w_clr[gi]);
            end
        end

        assign w_cnt[gi]       = r_cnt;
        assign w_irq_en[gi]    = r_irq_en;
        assign counter_OUT[gi] = r_out;
        assign irq_pend[gi]    = r_pend;
    end

    // Count readback mux; out-of-range channels match nothing and read 0.
    always_comb begin
        counter_out = {CNT_W{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            counter_out = counter_out | (w_cnt[k] & {CNT_W{rd_ch == CH_W'(k)}});
        end
    end

    assign irq = |(irq_pend & w_irq_en);

endmodule
